// File: rtl/fetch_unit_if.sv
// Fetch-unit bus bundle.
// Groups the two handshakes that the fetch unit takes part in:
//   - Instruction memory read: imem_req/imem_addr out, imem_ack/imem_rdata back.
//   - Decode delivery: inst_valid/inst_out/inst_pc out, inst_ready back.
// The master modport is the fetch unit's view. The slave modport is the view
// shared by the memory and decode side.
interface fetch_unit_if;
    logic        imem_req;
    logic [31:0] imem_addr;
    logic        imem_ack;
    logic [31:0] imem_rdata;
    logic        inst_valid;
    logic        inst_ready;
    logic [31:0] inst_out;
    logic [31:0] inst_pc;

    modport master (
        output imem_req,
        output imem_addr,
        input  imem_ack,
        input  imem_rdata,
        output inst_valid,
        input  inst_ready,
        output inst_out,
        output inst_pc
    );

    modport slave (
        input  imem_req,
        input  imem_addr,
        output imem_ack,
        output imem_rdata,
        input  inst_valid,
        output inst_ready,
        input  inst_out,
        input  inst_pc
    );
endinterface

// File: rtl/fetch_unit.sv
// Instruction-fetch stage between the PC register and decode.
//
// The PC register loads pc_next on every clock and has no enable. Fetch
// therefore stalls by returning pc_in on pc_next. The block issues word reads
// over a req/ack handshake. It holds one returned instruction for decode under
// valid/ready. It also handles branch/jump redirect, and it raises a sticky
// fault for a misaligned PC or a memory timeout.
//
// Ports:
//   clk             clock, rising edge
//   rst             asynchronous active-low reset
//   pc_in           current PC (PC register output)
//   pc_next         next PC (PC register input), combinational
//   redirect        branch/jump taken this cycle
//   redirect_target new PC when redirect=1
//   bus             imem req/addr/ack/rdata and inst valid/ready/out/pc
//   fault           sticky fault: misaligned PC or timeout
module fetch_unit #(
    parameter int TIMEOUT = 16,
    parameter int CNT_W   = 5
) (
    input  logic                clk,
    input  logic                rst,
    input  logic [31:0]         pc_in,
    output logic [31:0]         pc_next,
    input  logic                redirect,
    input  logic [31:0]         redirect_target,
    fetch_unit_if.master        bus,
    output logic                fault
);

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_REQ   = 2'd1,
        S_VALID = 2'd2,
        S_FAULT = 2'd3
    } state_t;

    state_t             state_reg, state_next;
    logic [CNT_W-1:0]   count_reg, count_next;
    logic [31:0]        inst_out_reg, inst_out_next;
    logic [31:0]        inst_pc_reg, inst_pc_next;
    logic               fault_reg, fault_next;
    logic               aligned;
    logic               imem_req_c;
    logic               inst_valid_c;

    assign aligned = (pc_in[1:0] == 2'b00);

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_reg    <= S_IDLE;
            count_reg    <= '0;
            inst_out_reg <= '0;
            inst_pc_reg  <= '0;
            fault_reg    <= 1'b0;
        end else begin
            state_reg    <= state_next;
            count_reg    <= count_next;
            inst_out_reg <= inst_out_next;
            inst_pc_reg  <= inst_pc_next;
            fault_reg    <= fault_next;
        end
    end

    always_comb begin
        state_next    = state_reg;
        count_next    = count_reg;
        inst_out_next = inst_out_reg;
        inst_pc_next  = inst_pc_reg;
        fault_next    = fault_reg;
        pc_next       = pc_in;
        imem_req_c    = 1'b0;
        inst_valid_c  = 1'b0;

        case (state_reg)
            S_IDLE: begin
                state_next = S_REQ;
                count_next = '0;
            end

            S_REQ: begin
                // A misaligned PC never reaches memory.
                imem_req_c = aligned;
                if (redirect) begin
                    // Abandon the request, or discard data acked this
                    // cycle, and restart at the target next cycle.
                    count_next = '0;
                end else if (!aligned) begin
                    fault_next = 1'b1;
                    count_next = '0;
                    state_next = S_FAULT;
                end else if (bus.imem_ack) begin
                    inst_out_next = bus.imem_rdata;
                    inst_pc_next  = pc_in;
                    pc_next       = pc_in + 32'd4;
                    count_next    = '0;
                    state_next    = S_VALID;
                end else if (count_reg == CNT_W'(TIMEOUT - 1)) begin
                    fault_next = 1'b1;
                    count_next = '0;
                    state_next = S_FAULT;
                end else begin
                    count_next = count_reg + CNT_W'(1);
                end
            end

            S_VALID: begin
                inst_valid_c = 1'b1;
                // Consume or flush. Decode decides which one a redirect means.
                if (redirect || bus.inst_ready) begin
                    state_next = S_REQ;
                end
            end

            S_FAULT: begin
                if (redirect) begin
                    fault_next = 1'b0;
                    count_next = '0;
                    state_next = S_REQ;
                end
            end

            default: begin
                state_next = S_IDLE;
            end
        endcase

        // A redirect outranks every other source of the next PC.
        if (redirect) begin
            pc_next = redirect_target;
        end
    end

    assign bus.imem_req   = imem_req_c;
    assign bus.imem_addr  = pc_in;
    assign bus.inst_valid = inst_valid_c;
    assign bus.inst_out   = inst_out_reg;
    assign bus.inst_pc    = inst_pc_reg;
    assign fault          = fault_reg;

endmodule

// File: tb/tb_fetch_unit.sv
// Bench for fetch_unit.
// The bench models the PC register, which loads pc_next every clock. The
// stimulus block can override that load. Each issued memory transaction
// pushes its expected address into a queue, and each instruction that decode
// should receive is pushed as well. A monitor pops the queues on each
// req&ack and each valid&ready handshake and compares the values. Directed
// checks cover the combinational outputs.
module tb_fetch_unit;

    logic        clk;
    logic        rst;
    logic [31:0] pc_in;
    logic [31:0] pc_next;
    logic        redirect;
    logic [31:0] redirect_target;
    logic        fault;
    logic        pc_load;
    logic [31:0] pc_load_val;

    int checks = 0;
    int errors = 0;

    logic [31:0] exp_addr[$];
    logic [63:0] exp_inst[$];   // {inst, pc}

    fetch_unit_if bus ();

    fetch_unit #(.TIMEOUT(16), .CNT_W(5)) dut (
        .clk             (clk),
        .rst             (rst),
        .pc_in           (pc_in),
        .pc_next         (pc_next),
        .redirect        (redirect),
        .redirect_target (redirect_target),
        .bus             (bus),
        .fault           (fault)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // PC register model
    always @(posedge clk) begin
        pc_in <= pc_load ? pc_load_val : pc_next;
    end

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%08h, expected 0x%08h (t=%0t)", name, act, exp, $time);
        end else begin
            $display("ok   %s = 0x%08h (t=%0t)", name, act, $time);
        end
    endtask

    // Drive one cycle's inputs at the falling edge. The task returns 1ns
    // later, once the combinational outputs have settled.
    task automatic cyc(input logic ack, input logic [31:0] rdata, input logic rd,
                       input logic [31:0] tgt, input logic rdy);
        @(negedge clk);
        bus.imem_ack    = ack;
        bus.imem_rdata  = rdata;
        redirect        = rd;
        redirect_target = tgt;
        bus.inst_ready  = rdy;
        #1;
    endtask

    // Scoreboard monitor
    always @(negedge clk) begin
        #2;
        if (rst === 1'b1 && bus.imem_req === 1'b1 && bus.imem_ack === 1'b1) begin
            if (exp_addr.size() == 0) begin
                checks++;
                errors++;
                $display("FAIL fetch_addr: unexpected request at 0x%08h, expected none", bus.imem_addr);
            end else begin
                check("fetch_addr", bus.imem_addr, exp_addr.pop_front());
            end
        end
        if (rst === 1'b1 && bus.inst_valid === 1'b1 && bus.inst_ready === 1'b1) begin
            if (exp_inst.size() == 0) begin
                checks++;
                errors++;
                $display("FAIL deliver: unexpected inst 0x%08h pc 0x%08h, expected none",
                         bus.inst_out, bus.inst_pc);
            end else begin
                logic [63:0] e;
                e = exp_inst.pop_front();
                check("deliver_inst", bus.inst_out, e[63:32]);
                check("deliver_pc", bus.inst_pc, e[31:0]);
            end
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish, expected finish");
        $fatal(1, "watchdog");
    end

    initial begin
        rst = 1'b0;
        pc_load = 1'b1;
        pc_load_val = 32'h0;
        redirect = 1'b0;
        redirect_target = 32'h0;
        bus.imem_ack = 1'b0;
        bus.imem_rdata = 32'h0;
        bus.inst_ready = 1'b0;

        repeat (3) @(posedge clk);
        @(negedge clk); #1;
        check("rst_req", {31'b0, bus.imem_req}, 32'd0);
        check("rst_valid", {31'b0, bus.inst_valid}, 32'd0);
        check("rst_inst_out", bus.inst_out, 32'h0);
        check("rst_inst_pc", bus.inst_pc, 32'h0);
        check("rst_fault", {31'b0, fault}, 32'd0);

        // Release reset: the first cycle is S_IDLE.
        @(negedge clk);
        rst = 1'b1;
        pc_load = 1'b0;
        #1;
        check("idle_req", {31'b0, bus.imem_req}, 32'd0);

        // Fetch at 0x0 with the ack in the same cycle as the request.
        cyc(1'b1, 32'h20080005, 1'b0, 32'h0, 1'b0);
        exp_addr.push_back(32'h0);
        exp_inst.push_back({32'h20080005, 32'h0});
        check("req0_req", {31'b0, bus.imem_req}, 32'd1);
        check("req0_addr", bus.imem_addr, 32'h0);
        check("req0_pc_next", pc_next, 32'h4);

        // Decode stalls for 5 cycles.
        for (int i = 0; i < 5; i++) begin
            cyc(1'b0, 32'h0, 1'b0, 32'h0, 1'b0);
            check("stall_valid", {31'b0, bus.inst_valid}, 32'd1);
            check("stall_inst", bus.inst_out, 32'h20080005);
            check("stall_pc", bus.inst_pc, 32'h0);
            check("stall_pc_next", pc_next, 32'h4);
            check("stall_req", {31'b0, bus.imem_req}, 32'd0);
        end
        cyc(1'b0, 32'h0, 1'b0, 32'h0, 1'b1);

        // Request at 0x4, redirected to 0x10 before the ack.
        cyc(1'b0, 32'h0, 1'b1, 32'h10, 1'b0);
        check("req4_addr", bus.imem_addr, 32'h4);
        check("req4_req", {31'b0, bus.imem_req}, 32'd1);
        check("redir_pc_next", pc_next, 32'h10);

        // 3 wait states at 0x10
        for (int i = 0; i < 3; i++) begin
            cyc(1'b0, 32'h0, 1'b0, 32'h0, 1'b0);
            check("wait_req", {31'b0, bus.imem_req}, 32'd1);
            check("wait_addr", bus.imem_addr, 32'h10);
            check("wait_pc_next", pc_next, 32'h10);
        end
        cyc(1'b1, 32'h8C090010, 1'b0, 32'h0, 1'b0);
        exp_addr.push_back(32'h10);
        exp_inst.push_back({32'h8C090010, 32'h10});
        check("ack10_pc_next", pc_next, 32'h14);
        cyc(1'b0, 32'h0, 1'b0, 32'h0, 1'b1);

        // At 0x14, redirect to 0x8. At 0x8, the ack and a redirect to 0x40
        // arrive together.
        cyc(1'b0, 32'h0, 1'b1, 32'h8, 1'b0);
        cyc(1'b1, 32'hDEADBEEF, 1'b1, 32'h40, 1'b0);
        exp_addr.push_back(32'h8);
        check("ackredir_pc_next", pc_next, 32'h40);
        cyc(1'b1, 32'h01234567, 1'b0, 32'h0, 1'b0);
        exp_addr.push_back(32'h40);
        check("discard_valid", {31'b0, bus.inst_valid}, 32'd0);
        check("discard_addr", bus.imem_addr, 32'h40);
        // The buffered instruction is flushed by a redirect in S_VALID.
        cyc(1'b0, 32'h0, 1'b1, 32'h40, 1'b0);
        check("flush_valid_before", {31'b0, bus.inst_valid}, 32'd1);
        check("flush_inst_pc", bus.inst_pc, 32'h40);
        check("flush_pc_next", pc_next, 32'h40);
        cyc(1'b1, 32'h00A00093, 1'b0, 32'h0, 1'b0);
        exp_addr.push_back(32'h40);
        exp_inst.push_back({32'h00A00093, 32'h40});
        check("flush_valid_after", {31'b0, bus.inst_valid}, 32'd0);
        check("refetch_addr", bus.imem_addr, 32'h40);
        cyc(1'b0, 32'h0, 1'b0, 32'h0, 1'b1);

        // Misaligned PC 0x6
        cyc(1'b0, 32'h0, 1'b1, 32'h6, 1'b0);
        cyc(1'b0, 32'h0, 1'b0, 32'h0, 1'b0);
        check("mis_req", {31'b0, bus.imem_req}, 32'd0);
        check("mis_pc_next", pc_next, 32'h6);
        for (int i = 0; i < 2; i++) begin
            cyc(1'b1, 32'hFFFFFFFF, 1'b0, 32'h0, 1'b0);
            check("mis_fault", {31'b0, fault}, 32'd1);
            check("mis_fault_req", {31'b0, bus.imem_req}, 32'd0);
            check("mis_hold_pc", pc_next, 32'h6);
        end
        cyc(1'b0, 32'h0, 1'b1, 32'h100, 1'b0);
        check("fault_redir_pc_next", pc_next, 32'h100);

        // Timeout at 0x100: 16 cycles of request without an ack
        for (int i = 0; i < 16; i++) begin
            cyc(1'b0, 32'h0, 1'b0, 32'h0, 1'b0);
            check("to_fault_clear", {31'b0, fault}, 32'd0);
            check("to_req", {31'b0, bus.imem_req}, 32'd1);
            check("to_addr", bus.imem_addr, 32'h100);
        end
        cyc(1'b0, 32'h0, 1'b0, 32'h0, 1'b0);
        check("to_fault", {31'b0, fault}, 32'd1);
        check("to_req_drop", {31'b0, bus.imem_req}, 32'd0);

        // The PC wraps from 0xFFFFFFFC to 0x0.
        cyc(1'b0, 32'h0, 1'b1, 32'hFFFFFFFC, 1'b0);
        cyc(1'b1, 32'h0000006F, 1'b0, 32'h0, 1'b0);
        exp_addr.push_back(32'hFFFFFFFC);
        exp_inst.push_back({32'h0000006F, 32'hFFFFFFFC});
        check("wrap_pc_next", pc_next, 32'h0);
        cyc(1'b0, 32'h0, 1'b0, 32'h0, 1'b1);
        check("wrap_pc_in", pc_next, 32'h0);

        // Reset asserted while waiting for the ack
        cyc(1'b0, 32'h0, 1'b0, 32'h0, 1'b0);
        check("pre_rst_req", {31'b0, bus.imem_req}, 32'd1);
        #2;
        rst = 1'b0;
        #1;
        check("async_rst_req", {31'b0, bus.imem_req}, 32'd0);
        check("async_rst_valid", {31'b0, bus.inst_valid}, 32'd0);
        cyc(1'b1, 32'h12345678, 1'b0, 32'h0, 1'b0);
        check("in_rst_req", {31'b0, bus.imem_req}, 32'd0);
        // Release with a late ack still high. S_IDLE ignores it.
        @(negedge clk);
        rst = 1'b1;
        #1;
        check("late_ack_req", {31'b0, bus.imem_req}, 32'd0);
        check("late_ack_valid", {31'b0, bus.inst_valid}, 32'd0);
        cyc(1'b0, 32'h0, 1'b0, 32'h0, 1'b0);
        check("post_rst_req", {31'b0, bus.imem_req}, 32'd1);
        check("post_rst_addr", bus.imem_addr, 32'h0);

        @(negedge clk); #3;
        check("addr_queue_drained", exp_addr.size(), 32'd0);
        check("inst_queue_drained", exp_inst.size(), 32'd0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/fetch_unit.md
Name: fetch_unit

Overview:
- Instruction-fetch stage between the PC register and decode.
- Consumes the PC register's output and drives its next-value input. The PC register loads every clock with no enable, so this block stalls fetch by feeding back the current PC.
- Issues word reads to instruction memory over a req/ack handshake.
- Holds the returned instruction in a one-entry buffer and presents it to decode with valid/ready.
- Handles branch/jump redirect and flags misaligned PC and memory timeout.

Parameters:
- TIMEOUT, 16: max cycles imem_req may stay high without imem_ack before fault.
- CNT_W, 5: width of timeout counter; must hold TIMEOUT.

Ports:
- clk  in  1  clock, rising edge
- rst  in  1  asynchronous active-low reset
- pc_in  in  32  current PC, from PC register output
- pc_next  out  32  next PC, to PC register input; combinational
- redirect  in  1  branch/jump taken this cycle
- redirect_target  in  32  new PC when redirect=1
- imem_req  out  1  read request; combinational from state
- imem_addr  out  32  read address, equals pc_in
- imem_ack  in  1  read data valid this cycle; may arrive in the same cycle as req
- imem_rdata  in  32  instruction word
- inst_valid  out  1  buffered instruction valid
- inst_ready  in  1  decode accepts the instruction
- inst_out  out  32  buffered instruction
- inst_pc  out  32  PC of the buffered instruction
- fault  out  1  sticky fault: misaligned PC or timeout

Behaviour:
- Reset (rst=0, asynchronous): state=S_IDLE; inst_valid=0, inst_out=0, inst_pc=0, fault=0, timeout count=0.
- States: S_IDLE, S_REQ, S_VALID, S_FAULT.
- Default: pc_next=pc_in (hold). A redirect in any state overrides this with pc_next=redirect_target; the redirect is the highest-priority event.
- S_IDLE:
  - imem_req=0.
  - Next cycle: S_REQ.
- S_REQ:
  - If pc_in[1:0]!=0: imem_req=0, fault<=1, go S_FAULT.
  - Otherwise imem_req=1, imem_addr=pc_in; count increments each cycle without ack.
  - On imem_ack without redirect: inst_out<=imem_rdata, inst_pc<=pc_in, pc_next=pc_in+4 (mod 2^32, wraps 0xFFFFFFFC->0), count<=0, go S_VALID.
  - On imem_ack with redirect: returned data is discarded, pc_next=redirect_target, count<=0, stay S_REQ.
  - Redirect without ack: request is abandoned; imem_req stays high with the new address next cycle; count<=0. The memory must tolerate an address change before ack.
  - If count reaches TIMEOUT-1 with no ack: fault<=1, go S_FAULT.
- S_VALID:
  - inst_valid=1, imem_req=0; pc_in already holds the advanced PC.
  - inst_ready=1: go S_REQ; inst_valid drops next cycle.
  - Redirect: buffered instruction flushed (inst_valid=0 next cycle), pc_next=redirect_target, go S_REQ. This applies regardless of inst_ready; the consumed-or-flushed decision belongs to decode.
  - inst_out and inst_pc remain stable while inst_valid=1 and inst_ready=0.
- S_FAULT:
  - imem_req=0, inst_valid=0, pc_next=pc_in.
  - Redirect: fault<=0, pc_next=redirect_target, go S_REQ.
- Throughput: 2 cycles per instruction with zero-wait memory (S_REQ + S_VALID); +1 cycle per memory wait state.
- Reset mid-transaction: imem_req drops immediately (asynchronous); any late ack is ignored while in S_IDLE.
- imem_ack in S_IDLE, S_VALID or S_FAULT is ignored.

Test Plan:
- Reset release, pc_in=0x0, ack same cycle, rdata=0x20080005 -> imem_req=1 addr=0x0 in cycle 2; pc_next=0x4; cycle 3 inst_valid=1, inst_out=0x20080005, inst_pc=0x0.
- inst_ready=0 for 5 cycles in S_VALID -> inst_out/inst_pc stable, pc_next=pc_in=0x4, imem_req=0; ready=1 -> next fetch addr=0x4.
- Ack delayed 3 cycles at pc_in=0x10 -> imem_req held 3 cycles, pc_next=0x10 throughout, then 0x14 on ack cycle.
- redirect=1, target=0x40 in the same cycle as ack at 0x8 -> data discarded, inst_valid stays 0, next req addr=0x40; redirect in S_VALID -> inst_valid drops, fetch 0x40.
- pc_in=0x6 -> no request, fault=1, pc held; redirect to 0x100 -> fault=0, req addr=0x100. No ack for 16 cycles -> fault=1, imem_req=0.
- pc_in=0xFFFFFFFC ack -> pc_next=0x0; assert rst=0 mid-wait -> imem_req=0, inst_valid=0 immediately.
